inverse_row_normalizer: RTL and testbench
=========================================

// Module: inverse_row_normalizer
// PURPOSE
//   Downstream stage of the fraction-free 5x5 matrix inverse. Takes the unnormalised
//   inverse rows i11..i55 and pivots pivot1..pivot5, divides each element by its row's pivot,
//   and streams 25 signed fixed-point results out in row-major order.
//   Uses one shared iterative restoring divider with valid/ready handshakes on both sides.
// PARAMETERS
//   W     32  element and pivot width (signed two's complement); output width
//   FRAC  16  fractional bits of output (result = num/piv scaled by 2^FRAC)
//   N     5   matrix dimension (fixed at 5; index ports sized 3 bits)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   in_valid  in   1      num_flat/piv_flat valid
//   in_ready  out  1      high only in IDLE; accepts a matrix on in_valid&in_ready
//   num_flat  in   N*N*W  element k=5r+c (i[r+1][c+1]) at [k*W +: W]
//   piv_flat  in   N*W    pivot r+1 at [r*W +: W]
//   out_valid out  1      out_* hold a result
//   out_ready in   1      consumer accepts on out_valid&out_ready
//   out_data  out  W      signed quotient, FRAC fractional bits
//   out_row   out  3      row index 0..4 of out_data
//   out_col   out  3      column index 0..4 of out_data
//   out_last  out  1      high with element k=24
//   div_zero  out  1      high with any element whose pivot is 0
//   busy      out  1      high in every state except IDLE
// BEHAVIOUR
//   Reset: state IDLE; in_ready=1; out_valid, out_data, out_row, out_col, out_last,
//     div_zero, busy = 0; internal matrix copy, index and divider regs cleared.
//   Capture: on in_valid&in_ready, register all of num_flat and piv_flat and set k=0.
//     Inputs are ignored (in_ready=0) until the 25th output handshake completes.
//   FSM: IDLE -> SETUP (1 cyc) -> DIV (W+FRAC cyc) -> FIX (1 cyc) -> OUT -> SETUP | IDLE.
//     SETUP: n=|num_k|, d=|piv_r| in W+1 bits (so |0x80000000| is exact);
//       sign = msb(num) ^ msb(piv); dividend = n<<FRAC (W+FRAC+1 bits).
//     DIV: one quotient bit per cycle, MSB first, restoring; quotient magnitude truncated
//       toward zero.
//     FIX: apply sign. Saturate: positive magnitude > 2^(W-1)-1 gives 0x7FFF_FFFF;
//       negative magnitude > 2^(W-1) gives 0x8000_0000.
//       If piv_r==0: skip-result = 0x7FFF_FFFF when num>=0, else 0x8000_0000;
//       div_zero=1 for that element. DIV still runs its full count so latency stays fixed.
//     OUT: out_valid=1. out_data/row/col/last/div_zero stay stable until out_ready.
//       On handshake: if k==24 go to IDLE with out_valid=0 next cycle; else k++ and go to SETUP.
//   Latency: out_valid rises on the (W+FRAC+2)th rising edge after the accept edge, or after
//     the previous output handshake edge (50 cycles at defaults). One matrix takes >= 25*50
//     cycles.
//   out_ready high in the same cycle out_valid rises: the handshake occurs that cycle
//     (no extra bubble).
//   out_ready ignored while out_valid=0; in_valid ignored while busy.
//   Reset mid-operation: immediate abandon; partial matrix discarded, nothing emitted after
//     release.
//   All outputs registered; in_ready = (state==IDLE), registered.
// TESTING
//   T1 all num=3, all piv=2 -> 25 outputs 0x0001_8000; rows/cols 0..4 in row-major order;
//      out_last only on 25th; first out_valid exactly 50 edges after accept.
//   T2 num=0xFFFF_FFF9 (-7), piv=4 -> 0xFFFE_4000 (-1.75); num=5, piv=0xFFFF_FFFD (-3)
//      -> 0xFFFE_5556 (trunc toward 0).
//   T3 piv3=0, row 2 nums {1,-1,0,7,-7} -> 0x7FFF_FFFF,0x8000_0000,0x7FFF_FFFF,0x7FFF_FFFF,
//      0x8000_0000 with div_zero=1 on those 5 only.
//   T4 num=0x7FFF_FFFF, piv=1 -> 0x7FFF_FFFF (saturated, div_zero=0);
//      num=0x8000_0000, piv=1 -> 0x8000_0000.
//   T5 out_ready low 10 cycles at element 7 -> out_* unchanged; no element 8 work starts;
//      in_valid pulses while busy are not accepted.
//   T6 assert rst during DIV of element 12 -> all outputs 0 and in_ready=1 after release;
//      new matrix accepted, all 25 correct.

Source files
------------

// File: rtl/inverse_row_normalizer.sv
`timescale 1ns/1ps
// Divides each element of a 5x5 unnormalised inverse by its row pivot using one shared
// restoring divider, streaming 25 signed fixed-point quotients in row-major order.
module inverse_row_normalizer #(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int N    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] num_flat,
  input  logic [N*W-1:0]   piv_flat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [2:0]       out_row,
  output logic [2:0]       out_col,
  output logic             out_last,
  output logic             div_zero,
  output logic             busy
);
  localparam int NN = N * N;
  localparam int QW = W + FRAC;
  localparam int CW = $clog2(QW);
  localparam int KW = $clog2(NN);

  localparam logic [W-1:0]  SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  SAT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [QW-1:0] POS_LIM = {{(QW-W){1'b0}}, SAT_MAX};
  localparam logic [QW-1:0] NEG_LIM = {{(QW-W){1'b0}}, SAT_MIN};

  typedef enum logic [2:0] {IDLE, SETUP, DIV, FIX, OUT} state_t;

  state_t        state_q;
  logic [W-1:0]  num_q [NN];
  logic [W-1:0]  piv_q [N];
  logic [KW-1:0] k_q;
  logic [2:0]    row_q;
  logic [2:0]    col_q;
  logic [QW-1:0] dvd_q;
  logic [QW-1:0] quo_q;
  logic [W:0]    rem_q;
  logic [W:0]    den_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q;
  logic          num_neg_q;
  logic          piv_zero_q;

  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [2:0]    out_row_q;
  logic [2:0]    out_col_q;
  logic          out_last_q;
  logic          div_zero_q;
  logic          busy_q;

  logic          accept;
  logic [W-1:0]  sel_num_d;
  logic [W-1:0]  sel_piv_d;
  logic [W-1:0]  num_abs_d;
  logic [W-1:0]  piv_abs_d;
  logic [W+1:0]  trial_d;
  logic          trial_ge_d;
  logic [W-1:0]  fix_d;

  assign accept = (state_q == IDLE) && in_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_num
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          num_q[gi] <= '0;
        end else if (accept) begin
          num_q[gi] <= num_flat[gi*W +: W];
        end
      end
    end
    for (gi = 0; gi < N; gi++) begin : g_piv
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          piv_q[gi] <= '0;
        end else if (accept) begin
          piv_q[gi] <= piv_flat[gi*W +: W];
        end
      end
    end
  endgenerate

  // Magnitudes are unsigned W-bit values, so the most negative input maps exactly to 2^(W-1).
  always_comb begin
    sel_num_d  = num_q[k_q];
    sel_piv_d  = piv_q[row_q];
    num_abs_d  = sel_num_d[W-1] ? (~sel_num_d + W'(1)) : sel_num_d;
    piv_abs_d  = sel_piv_d[W-1] ? (~sel_piv_d + W'(1)) : sel_piv_d;
    trial_d    = {rem_q, dvd_q[QW-1]};
    trial_ge_d = (trial_d >= {1'b0, den_q});
    if (piv_zero_q) begin
      fix_d = num_neg_q ? SAT_MIN : SAT_MAX;
    end else if (!sign_q) begin
      fix_d = (quo_q > POS_LIM) ? SAT_MAX : quo_q[W-1:0];
    end else begin
      fix_d = (quo_q > NEG_LIM) ? SAT_MIN : (~quo_q[W-1:0] + W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      den_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      num_neg_q   <= 1'b0;
      piv_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= SETUP;
            k_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SETUP: begin
          den_q      <= {1'b0, piv_abs_d};
          dvd_q      <= {num_abs_d, {FRAC{1'b0}}};
          rem_q      <= '0;
          quo_q      <= '0;
          sign_q     <= sel_num_d[W-1] ^ sel_piv_d[W-1];
          num_neg_q  <= sel_num_d[W-1];
          piv_zero_q <= (sel_piv_d == '0);
          cnt_q      <= CW'(QW - 1);
          state_q    <= DIV;
        end
        DIV: begin
          // A zero pivot still iterates the full count so every element has equal latency.
          rem_q <= trial_ge_d ? (W+1)'(trial_d - {1'b0, den_q}) : trial_d[W:0];
          dvd_q <= {dvd_q[QW-2:0], 1'b0};
          quo_q <= {quo_q[QW-2:0], trial_ge_d};
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIX: begin
          out_valid_q <= 1'b1;
          out_data_q  <= fix_d;
          out_row_q   <= row_q;
          out_col_q   <= col_q;
          out_last_q  <= (k_q == KW'(NN - 1));
          div_zero_q  <= piv_zero_q;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (k_q == KW'(NN - 1)) begin
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              k_q     <= k_q + KW'(1);
              state_q <= SETUP;
              if (col_q == 3'(N - 1)) begin
                col_q <= '0;
                row_q <= row_q + 3'd1;
              end else begin
                col_q <= col_q + 3'd1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign div_zero  = div_zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inverse_row_normalizer.sv
`timescale 1ns/1ps
// Scoreboard bench for inverse_row_normalizer: directed matrices with hand-computed quotients,
// output stall, busy-time input pulses and a mid-divide reset.
module tb_inverse_row_normalizer;
  localparam int W = 32;
  localparam int N = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N*N*W-1:0] num_flat;
  logic [N*W-1:0]   piv_flat;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [2:0]       out_row;
  logic [2:0]       out_col;
  logic             out_last;
  logic             div_zero;
  logic             busy;

  always #5 clk = ~clk;

  inverse_row_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num_flat  (num_flat),
    .piv_flat  (piv_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
    logic        dz;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          hs_cnt = 0;
  logic [31:0] m_num [25];
  logic [31:0] m_piv [5];
  logic [31:0] m_exp [25];
  logic        m_dz  [25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: a handshake completes at the next rising edge when valid&ready hold now.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got data=%h row=%0d col=%0d, expected no output",
                 out_data, out_row, out_col);
      end else begin
        e = exp_q.pop_front();
        $display("out #%0d row=%0d col=%0d data=%h last=%0d dz=%0d (expect %h)",
                 hs_cnt, out_row, out_col, out_data, out_last, div_zero, e.data);
        check("out_element", {out_data, out_row, out_col, out_last, div_zero}, e);
      end
      hs_cnt++;
    end
  end

  task automatic load_t1();
    for (int i = 0; i < 25; i++) begin
      m_num[i] = 32'd3;
      m_exp[i] = 32'h0001_8000;
      m_dz[i]  = 1'b0;
    end
    for (int r = 0; r < 5; r++) m_piv[r] = 32'd2;
  endtask

  task automatic load_m2();
    m_num = '{32'hFFFF_FFF9, 32'h0000_0008, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
              32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006,
              32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFF9,
              32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_0001,
              32'h4000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF};
    m_piv = '{32'h0000_0004, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
    m_exp = '{32'hFFFE_4000, 32'h0002_0000, 32'h0000_0000, 32'h0000_4000, 32'hFFFF_C000,
              32'hFFFE_5556, 32'h0001_AAAA, 32'hFFFF_0000, 32'h0000_0000, 32'hFFFE_0000,
              32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
              32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000,
              32'hFFFF_8000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_0001};
    for (int i = 0; i < 25; i++) m_dz[i] = (i >= 10 && i < 15);
  endtask

  task automatic issue();
    int   guard = 0;
    exp_t e;
    while (!in_ready && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 25; i++) begin
      num_flat[i*W +: W] = m_num[i];
      e.data = m_exp[i];
      e.row  = 3'(i / 5);
      e.col  = 3'(i % 5);
      e.last = (i == 24);
      e.dz   = m_dz[i];
      exp_q.push_back(e);
    end
    for (int r = 0; r < 5; r++) piv_flat[r*W +: W] = m_piv[r];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(hs_cnt), 64'(target));
  endtask

  task automatic check_reset_state(input string name);
    check(name, {in_ready, out_valid, busy, out_data, out_row, out_col, out_last, div_zero},
          {1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b0});
  endtask

  initial begin
    int base;
    int lat;
    int guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    num_flat = '0; piv_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset_held");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("reset_released");

    // T1 + T5: uniform 3/2 matrix, latency, stall at element 7, ignored busy inputs
    load_t1();
    base = hs_cnt;
    issue();
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    check("first_latency", 64'(lat), 64'd50);
    check("busy_during_work", {62'd0, busy, in_ready}, {62'd0, 1'b1, 1'b0});
    wait_hs(base + 7, 600, "reach_element7");
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("stall_valid", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0);
      num_flat = {25{32'h1234_5678}};
      check("stall_hold", {out_valid, out_data, out_row, out_col, out_last, div_zero, in_ready, busy},
            {1'b1, 32'h0001_8000, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    in_valid = 1'b0;
    check("stall_no_advance", 64'(hs_cnt), 64'(base + 7));
    out_ready = 1'b1;
    wait_hs(base + 25, 25 * 60, "t1_complete");
    check("t1_idle", {61'd0, in_ready, busy, out_valid}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // T2-T4: signs, truncation, zero pivot, saturation boundaries
    load_m2();
    base = hs_cnt;
    issue();
    wait_hs(base + 25, 25 * 60, "m2_complete");
    check("m2_queue_empty", 64'(exp_q.size()), 64'd0);

    // T6: reset during the divide of element 12
    base = hs_cnt;
    issue();
    wait_hs(base + 12, 12 * 60, "reach_element12");
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_state("mid_reset_state");
    base = hs_cnt;
    repeat (100) @(posedge clk);
    #1;
    check("no_output_after_reset", 64'(hs_cnt), 64'(base));
    issue();
    wait_hs(base + 25, 25 * 60, "post_reset_complete");
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far",
             pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
